// File: rtl/gpr_file_snap.sv
// Architectural GPR file with two combinational read ports, one write port and a
// commit-aligned flattened snapshot that the register-export and difftest stages consume.
module gpr_file_snap #(
    parameter int NR_REGS = 32,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [4:0]              raddr1,
    output logic [31:0]             rdata1,
    input  logic [4:0]              raddr2,
    output logic [31:0]             rdata2,
    input  logic                    we,
    input  logic [4:0]              waddr,
    input  logic [31:0]             wdata,
    input  logic                    commit_valid,
    output logic [NR_REGS*32-1:0]   gprs,
    output logic                    snap_valid,
    output logic [31:0]             retire_cnt,
    output logic                    bad_waddr
);

    localparam int         AW = $clog2(NR_REGS);
    localparam logic [5:0] NR = 6'(NR_REGS);

    generate
        if (NR_REGS != 16 && NR_REGS != 32) begin : g_bad_cfg
            $error("gpr_file_snap: NR_REGS must be 16 or 32");
        end
    endgenerate

    logic [31:0]           regs      [NR_REGS];
    logic [31:0]           next_regs [NR_REGS];
    logic [NR_REGS*32-1:0] next_flat;
    logic                  wr_legal;
    logic                  wr_bad;

    assign wr_bad   = we && ({1'b0, waddr} >= NR);
    assign wr_legal = we && (waddr != 5'd0) && !wr_bad;

    // The post-write image is what a commit captures, so a retiring instruction's own write is visible.
    always_comb begin
        next_regs = regs;
        if (wr_legal) begin
            next_regs[waddr[AW-1:0]] = wdata;
        end
    end

    always_comb begin
        next_flat = '0;
        for (int i = 0; i < NR_REGS; i++) begin
            next_flat[32*i +: 32] = next_regs[i];
        end
    end

    function automatic logic [31:0] read_port(input logic [4:0] raddr);
        logic [31:0] r;
        r = '0;
        if (raddr == 5'd0 || {1'b0, raddr} >= NR) begin
            r = '0;
        end else if (BYPASS && we && (waddr == raddr)) begin
            r = wdata;
        end else begin
            r = regs[raddr[AW-1:0]];
        end
        return r;
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

    // x0 is never written, so both regs[0] and the x0 slot of gprs stay zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs[i] <= '0;
            end
            gprs       <= '0;
            snap_valid <= 1'b0;
            retire_cnt <= '0;
            bad_waddr  <= 1'b0;
        end else begin
            regs       <= next_regs;
            snap_valid <= commit_valid;
            if (wr_bad) begin
                bad_waddr <= 1'b1;
            end
            if (commit_valid) begin
                gprs       <= next_flat;
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_gpr_file_snap.sv
// Self-checking bench: an RV32I write-first instance and an RV32E stored-read instance
// share one stimulus stream and are compared against an array-based reference model.
module tb_gpr_file_snap;

    logic        clk;
    logic        resetn;
    logic [4:0]  raddr1, raddr2, waddr;
    logic        we, commit_valid;
    logic [31:0] wdata;

    logic [31:0]   rdata1_32, rdata2_32, retire_cnt_32;
    logic [1023:0] gprs_32;
    logic          snap_valid_32, bad_waddr_32;
    logic [31:0]   rdata1_16, rdata2_16, retire_cnt_16;
    logic [511:0]  gprs_16;
    logic          snap_valid_16, bad_waddr_16;

    int vectors;
    int miscompares;

    // Reference state: index 0 = 32 regs write-first, index 1 = 16 regs stored-read
    logic [31:0] mreg  [2][32];
    logic [31:0] msnap [2][32];
    logic        mbad  [2];
    logic        msv;
    logic [31:0] mcnt;

    gpr_file_snap #(.NR_REGS(32), .BYPASS(1'b1)) dut32 (
        .clk(clk), .resetn(resetn),
        .raddr1(raddr1), .rdata1(rdata1_32), .raddr2(raddr2), .rdata2(rdata2_32),
        .we(we), .waddr(waddr), .wdata(wdata), .commit_valid(commit_valid),
        .gprs(gprs_32), .snap_valid(snap_valid_32), .retire_cnt(retire_cnt_32),
        .bad_waddr(bad_waddr_32)
    );

    gpr_file_snap #(.NR_REGS(16), .BYPASS(1'b0)) dut16 (
        .clk(clk), .resetn(resetn),
        .raddr1(raddr1), .rdata1(rdata1_16), .raddr2(raddr2), .rdata2(rdata2_16),
        .we(we), .waddr(waddr), .wdata(wdata), .commit_valid(commit_valid),
        .gprs(gprs_16), .snap_valid(snap_valid_16), .retire_cnt(retire_cnt_16),
        .bad_waddr(bad_waddr_16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nrOf(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic logic [31:0] expRead(input int k, input logic [4:0] a);
        if (a == 5'd0 || int'(a) >= nrOf(k)) return 32'd0;
        if (k == 0 && we && waddr == a) return wdata;
        return mreg[k][a];
    endfunction

    function automatic logic [1023:0] expSnap(input int k);
        logic [1023:0] v;
        v = '0;
        for (int i = 0; i < nrOf(k); i++) v[32*i +: 32] = msnap[k][i];
        return v;
    endfunction

    task automatic modelEdge();
        if (!resetn) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 32; i++) begin
                    mreg[k][i]  = '0;
                    msnap[k][i] = '0;
                end
                mbad[k] = 1'b0;
            end
            msv  = 1'b0;
            mcnt = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (we && int'(waddr) >= nrOf(k)) mbad[k] = 1'b1;
                if (we && waddr != 5'd0 && int'(waddr) < nrOf(k)) mreg[k][waddr] = wdata;
                if (commit_valid) begin
                    for (int i = 0; i < 32; i++) msnap[k][i] = mreg[k][i];
                end
            end
            msv = commit_valid;
            if (commit_valid) mcnt = mcnt + 32'd1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: check combinational reads before the edge, registered state after it.
    task automatic applyStimulus(input logic rn, input logic wen, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic cv,
                                 input logic [4:0] a1, input logic [4:0] a2);
        resetn = rn; we = wen; waddr = wa; wdata = wd; commit_valid = cv;
        raddr1 = a1; raddr2 = a2;
        #2;
        checkOutput("rdata1_32", {992'd0, rdata1_32}, {992'd0, expRead(0, a1)});
        checkOutput("rdata2_32", {992'd0, rdata2_32}, {992'd0, expRead(0, a2)});
        checkOutput("rdata1_16", {992'd0, rdata1_16}, {992'd0, expRead(1, a1)});
        checkOutput("rdata2_16", {992'd0, rdata2_16}, {992'd0, expRead(1, a2)});
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("gprs_32",       gprs_32,                  expSnap(0));
        checkOutput("gprs_16",       {512'd0, gprs_16},        expSnap(1));
        checkOutput("snap_valid_32", {1023'd0, snap_valid_32}, {1023'd0, msv});
        checkOutput("snap_valid_16", {1023'd0, snap_valid_16}, {1023'd0, msv});
        checkOutput("retire_cnt_32", {992'd0, retire_cnt_32},  {992'd0, mcnt});
        checkOutput("retire_cnt_16", {992'd0, retire_cnt_16},  {992'd0, mcnt});
        checkOutput("bad_waddr_32",  {1023'd0, bad_waddr_32},  {1023'd0, mbad[0]});
        checkOutput("bad_waddr_16",  {1023'd0, bad_waddr_16},  {1023'd0, mbad[1]});
    endtask

    initial begin
        logic [4:0] wa;
        vectors = 0;
        miscompares = 0;
        resetn = 1'b0; we = 1'b0; waddr = '0; wdata = '0; commit_valid = 1'b0;
        raddr1 = '0; raddr2 = '0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) begin
                mreg[k][i] = '0;
                msnap[k][i] = '0;
            end
            mbad[k] = 1'b0;
        end
        msv = 1'b0;
        mcnt = '0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] starting directed steps");

        // Random writes, then reset held for two cycles
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'd1, 5'd2);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd9);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd12);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd1, 5'd31);

        // x5 written with commit, read in the same cycle, then observed in the snapshot
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd5);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);

        // x0 write is dropped
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5);

        // Out-of-range write for the 16-register instance; bad flag must stick
        applyStimulus(1'b1, 1'b1, 5'd20, 32'hAAAA5555, 1'b1, 5'd20, 5'd20);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd20, 5'd4);
        applyStimulus(1'b1, 1'b1, 5'd4, 32'h44, 1'b0, 5'd20, 5'd4);

        // Uncommitted write to x3, then a commit with we=0 two cycles later
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h11, 1'b0, 5'd3, 5'd3);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd0);

        // Counter wrap from all-ones
        force dut32.retire_cnt = 32'hFFFFFFFF;
        force dut16.retire_cnt = 32'hFFFFFFFF;
        #1;
        release dut32.retire_cnt;
        release dut16.retire_cnt;
        mcnt = 32'hFFFFFFFF;
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);

        // Reset on the same edge as a committed write to x7
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd0);
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h7777, 1'b1, 5'd7, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd7);

        $display("[TB] starting random steps");
        for (int i = 0; i < 300; i++) begin
            wa = 5'($urandom_range(0, 31));
            applyStimulus(($urandom_range(0, 24) != 0),
                          ($urandom_range(0, 3) != 0),
                          wa, $urandom,
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gpr_file_snap.md
Name: gpr_file_snap

Overview:
Architectural general-purpose register file for the core. Provides two combinational read ports and one write port, with x0 hard-wired to zero. Maintains a commit-aligned snapshot of all registers, flattened onto one bus. The snapshot feeds the downstream DPI register-export stage (16-register or 32-register variant) and the difftest tooling, so the simulator sees architectural state only at retirement boundaries.

Parameters:
NR_REGS, 32, number of GPRs; legal values 16 (RV32E) or 32 (RV32I); any other value is an elaboration error.
BYPASS, 1, 1 = read ports return same-cycle write data (write-first); 0 = read ports return stored value only.

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
raddr1  input  5  read port 1 address
rdata1  output  32  read port 1 data, combinational
raddr2  input  5  read port 2 address
rdata2  output  32  read port 2 data, combinational
we  input  1  write enable
waddr  input  5  write address
wdata  input  32  write data
commit_valid  input  1  one instruction retires this cycle; its write (if any) is presented on we/waddr/wdata in the same cycle
gprs  output  NR_REGS*32  flattened snapshot; register i at bits [32*i+31:32*i]
snap_valid  output  1  pulses 1 cycle after each accepted commit
retire_cnt  output  32  number of commits since reset
bad_waddr  output  1  sticky; set on any write with waddr >= NR_REGS

Behaviour:
- Reset: already decided — reset is resetn, synchronous, active-low; clock is clk.
- Registers cleared by reset: all regs, gprs, snap_valid, retire_cnt, bad_waddr; each clears to 0 on the first posedge with resetn=0.
- rdata1/rdata2 are combinational and follow the registers, so they read 0 after reset.
- A reset arriving mid-stream discards any write or commit in that same cycle.
- Write:
  - On posedge with resetn=1, we=1, 0<waddr<NR_REGS: reg[waddr] <= wdata.
  - waddr=0: write is dropped silently.
  - waddr>=NR_REGS: write is dropped and bad_waddr <= 1. bad_waddr stays set until reset.
- Read:
  - rdata = 0 if raddr=0 or raddr>=NR_REGS.
  - Else, if BYPASS=1 and we=1 and waddr==raddr: rdata = wdata.
  - Else rdata = reg[raddr].
  - Both ports are independent and may use the same address.
- Snapshot:
  - On posedge with resetn=1 and commit_valid=1, gprs <= post-write register image. This is the register array with the same-cycle legal write applied, so the commit's own write is visible.
  - snap_valid <= commit_valid on every posedge; it is a 1-cycle pulse per commit, and back-to-back commits hold it high.
  - Without commit_valid, gprs holds its value even when registers change. Writes without commit (e.g. speculative writeback) never reach gprs until a later commit.
  - The x0 slot of gprs is always 0.
- retire_cnt:
  - Increments by 1 on each commit_valid=1 edge.
  - Wraps from 0xFFFFFFFF to 0.
- Latency: write to read is 0 cycles with BYPASS=1, 1 cycle with BYPASS=0. Write to gprs is 1 edge when commit_valid is asserted in the same cycle.
- Simultaneous events:
  - write plus commit to the same register: snapshot holds the new value.
  - commit with we=0: snapshot refreshes from current registers.
  - bad write plus commit: snapshot is unchanged in contents, retire_cnt still increments, bad_waddr is set.

Test Plan:
- Reset with resetn=0 for 2 cycles after random writes -> all rdata=0, gprs=0, retire_cnt=0, snap_valid=0, bad_waddr=0.
- Write x5=0xDEADBEEF with commit_valid=1, raddr1=5 in the same cycle:
  - BYPASS=1: rdata1=0xDEADBEEF in that cycle.
  - Next cycle: gprs[191:160]=0xDEADBEEF, snap_valid=1, retire_cnt=1.
- Write x0=0x12345678 with commit -> rdata1(raddr=0)=0 and gprs[31:0]=0 afterwards.
- NR_REGS=16: write x20=0xAAAA5555 -> no register changes, bad_waddr=1 and sticky; raddr1=20 reads 0.
- Write x3=0x11 without commit, then commit with we=0 two cycles later:
  - gprs[127:96] stays 0 until the commit edge, then becomes 0x11.
  - snap_valid is a single pulse.
- Force retire_cnt to 0xFFFFFFFF (preload via 2^32-1 commits or a backdoor), one more commit -> retire_cnt=0.
- Issue a write to x7 with commit and resetn=0 on the same edge -> x7=0, gprs=0, retire_cnt=0.
